// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: control inputs from decode/EX, imem read path and IF/ID outputs.
interface fetch_ctrl_if;
  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [31:0] imem_instr;
  logic [63:0] pc;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        halted;
  logic        imem_error;
  logic [31:0] fetch_count;

  modport master (
    output start, stall, branch_taken, branch_target, imem_instr,
    input  pc, if_id_pc, if_id_instr, if_id_valid, halted, imem_error, fetch_count
  );

  modport slave (
    input  start, stall, branch_taken, branch_target, imem_instr,
    output pc, if_id_pc, if_id_instr, if_id_valid, halted, imem_error, fetch_count
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, loads IF/ID, handles stalls, redirects
// and fetch faults, and halts the front end on a fault or end of program.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned IMEM_BYTES = 1024,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter logic [31:0] END_INSTR  = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.slave  bus
);

  localparam logic [63:0] IMEM_LIMIT = 64'(IMEM_BYTES);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        err_q, err_d;
  logic [31:0] count_q, count_d;
  logic        bad_target;

  assign bad_target = (bus.branch_target[1:0] != 2'b00) || (bus.branch_target >= IMEM_LIMIT);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
      valid_q       <= 1'b0;
      halted_q      <= 1'b0;
      err_q         <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      valid_q       <= valid_d;
      halted_q      <= halted_d;
      err_q         <= err_d;
      count_q       <= count_d;
    end
  end

  // Next-state and next-register values; RUN actions are taken in priority order.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    valid_d       = valid_q;
    halted_d      = halted_q;
    err_d         = err_q;
    count_d       = count_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        if (bus.branch_taken) begin
          valid_d       = 1'b0;
          if_id_instr_d = NOP_INSTR;
          if (bad_target) begin
            state_d  = HALT;
            halted_d = 1'b1;
            err_d    = 1'b1;
          end else begin
            pc_d = bus.branch_target;
          end
        end else if (bus.stall) begin
          valid_d = valid_q;
        end else if (pc_q >= IMEM_LIMIT) begin
          state_d  = HALT;
          halted_d = 1'b1;
          err_d    = 1'b1;
          valid_d  = 1'b0;
        end else if (bus.imem_instr == END_INSTR) begin
          state_d  = HALT;
          halted_d = 1'b1;
          err_d    = 1'b0;
          valid_d  = 1'b0;
        end else begin
          if_id_pc_d    = pc_q;
          if_id_instr_d = bus.imem_instr;
          valid_d       = 1'b1;
          pc_d          = pc_q + 64'd4;
          if (count_q != '1) count_d = count_q + 32'd1;
        end
      end
      HALT: begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.if_id_pc    = if_id_pc_q;
  assign bus.if_id_instr = if_id_instr_q;
  assign bus.if_id_valid = valid_q;
  assign bus.halted      = halted_q;
  assign bus.imem_error  = err_q;
  assign bus.fetch_count = count_q;

endmodule
